// File: rtl/risk_pkg.sv
// risk_pkg: shared widths, LFSR polynomial and FSM states for the Monte-Carlo P&L engine.
package risk_pkg;
    localparam int IN_W   = 18;
    localparam int ACC_W  = 27;
    localparam int Z_W    = 15;
    localparam int R_W    = 21;
    localparam int DS_W   = 25;
    localparam int Q_W    = 35;
    localparam int FRAC   = 14;
    localparam int Z_FRAC = 11;
    // Right-shifting Galois form of x^32+x^22+x^2+x+1
    localparam logic [31:0] LFSR_TAPS = 32'h80200003;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction
endpackage

// File: rtl/clt_gauss_rng.sv
// clt_gauss_rng: two free-running LFSRs; the sum of four 12-bit uniforms gives a centred Q3.11 Gaussian shock.
module clt_gauss_rng import risk_pkg::*; #(
    parameter logic [31:0] SEED_A = 32'hACE12468,
    parameter logic [31:0] SEED_B = 32'h1F2E3D4C
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic signed [Z_W-1:0] z_o
);
    logic [31:0] a_q, b_q;
    logic [13:0] usum;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q <= SEED_A;
            b_q <= SEED_B;
        end else begin
            a_q <= lfsr_step(a_q);
            b_q <= lfsr_step(b_q);
        end
    end
    assign usum = 14'(a_q[11:0]) + 14'(a_q[23:12]) + 14'(b_q[11:0]) + 14'(b_q[23:12]);
    assign z_o  = $signed({1'b0, usum}) - 15'sd8190;
endmodule

// File: rtl/risk_mc_main.sv
// risk_mc_main: batch FSM, input latches, dS / dS^2 pipeline and saturating accumulators.
module risk_mc_main import risk_pkg::*; #(
    parameter int          N_SAMPLES = 256,
    parameter logic [31:0] SEED_A    = 32'hACE12468,
    parameter logic [31:0] SEED_B    = 32'h1F2E3D4C
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    iDoneOptionCalc,
    input  logic [IN_W-1:0]         iMu,
    input  logic [IN_W-1:0]         iS,
    input  logic [IN_W-1:0]         iSigma,
    output logic signed [ACC_W-1:0] oAcc1,
    output logic [ACC_W-1:0]        oAcc2
);
    localparam int CNT_W = $clog2(N_SAMPLES) + 2;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IN_W-1:0]           mu_q, s_q, sigma_q;
    logic                      start;
    logic signed [Z_W-1:0]     z, z_q;
    logic signed [R_W-1:0]     r_q;
    logic signed [DS_W-1:0]    ds_q, ds4_q;
    logic [Q_W-1:0]            q_q;
    logic                      v1_q, v2_q, v3_q, v4_q;
    logic signed [IN_W+Z_W:0]  sz;
    logic signed [IN_W+R_W:0]  sr;
    logic signed [2*DS_W-1:0]  dsq;
    logic signed [ACC_W:0]     s1;
    logic [Q_W:0]              s2;
    logic signed [ACC_W-1:0]   acc1_q, acc1_d;
    logic [ACC_W-1:0]          acc2_q, acc2_d;

    clt_gauss_rng #(.SEED_A(SEED_A), .SEED_B(SEED_B)) u_rng (
        .clk_i (CLK),
        .rst_i (RST),
        .z_o   (z)
    );

    assign start = (state_q == IDLE) && iDoneOptionCalc;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                state_d = iDoneOptionCalc ? RUN : IDLE;
            end
            RUN: if (cnt_q == CNT_W'(N_SAMPLES - 1)) begin
                state_d = DRAIN;
                cnt_d   = '0;
            end
            DRAIN: state_d = (cnt_q == CNT_W'(3)) ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mu_q    <= '0;
            s_q     <= '0;
            sigma_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (start) begin
                mu_q    <= iMu;
                s_q     <= iS;
                sigma_q <= iSigma;
            end
        end
    end

    assign sz  = $signed({1'b0, sigma_q}) * z_q;
    assign sr  = $signed({1'b0, s_q}) * r_q;
    assign dsq = ds_q * ds_q;
    // Clamp on every add so a saturated sum can still move back in range
    assign s1     = (ACC_W+1)'(acc1_q) + (ACC_W+1)'(ds4_q);
    assign acc1_d = (s1[ACC_W] != s1[ACC_W-1]) ? {s1[ACC_W], {(ACC_W-1){~s1[ACC_W]}}} : s1[ACC_W-1:0];
    assign s2     = (Q_W+1)'(acc2_q) + (Q_W+1)'(q_q);
    assign acc2_d = (|s2[Q_W:ACC_W]) ? '1 : s2[ACC_W-1:0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            {v1_q, v2_q, v3_q, v4_q} <= '0;
            z_q    <= '0;
            r_q    <= '0;
            ds_q   <= '0;
            ds4_q  <= '0;
            q_q    <= '0;
            acc1_q <= '0;
            acc2_q <= '0;
        end else begin
            v1_q  <= (state_q == RUN);
            v2_q  <= v1_q;
            v3_q  <= v2_q;
            v4_q  <= v3_q;
            z_q   <= z;
            r_q   <= R_W'($signed({1'b0, mu_q}) + (sz >>> Z_FRAC));
            ds_q  <= DS_W'(sr >>> FRAC);
            ds4_q <= ds_q;
            q_q   <= Q_W'(dsq >>> FRAC);
            if (start) begin
                acc1_q <= '0;
                acc2_q <= '0;
            end else if (v4_q) begin
                acc1_q <= acc1_d;
                acc2_q <= acc2_d;
            end
        end
    end

    assign oAcc1 = acc1_q;
    assign oAcc2 = acc2_q;
endmodule

// File: tb/tb_risk_mc_main.sv
// tb_risk_mc_main: directed checks of latency, saturation, restart rules, reset and a reference model of the random batch.
module tb_risk_mc_main;
    localparam int          N      = 256;
    localparam logic [31:0] SEED_A = 32'hACE12468;
    localparam logic [31:0] SEED_B = 32'h1F2E3D4C;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic               start = 1'b0;
    logic [17:0]        mu = '0, s = '0, sigma = '0;
    logic signed [26:0] acc1;
    logic [26:0]        acc2;
    int                 checks = 0, errors = 0, ecnt = 0, c0 = 0;
    longint             e1, e2, r1a, r1b;

    risk_mc_main #(.N_SAMPLES(N), .SEED_A(SEED_A), .SEED_B(SEED_B)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .iDoneOptionCalc (start),
        .iMu             (mu),
        .iS              (s),
        .iSigma          (sigma),
        .oAcc1           (acc1),
        .oAcc2           (acc2)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK or posedge RST)
        if (RST) ecnt <= 0;
        else ecnt <= ecnt + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] step(input logic [31:0] x);
        return {1'b0, x[31:1]} ^ (x[0] ? 32'h80200003 : 32'h0);
    endfunction

    function automatic void model(input int steps, input longint m, input longint sv, input longint sg,
                                  output longint a1, output longint a2);
        logic [31:0] a = SEED_A, b = SEED_B;
        longint z, r, d, q;
        a1 = 0;
        a2 = 0;
        for (int i = 0; i < steps; i++) begin
            a = step(a);
            b = step(b);
        end
        for (int k = 0; k < N; k++) begin
            z = 64'(a[11:0]) + 64'(a[23:12]) + 64'(b[11:0]) + 64'(b[23:12]);
            z = z - 8190;
            r = m + ((sg * z) >>> 11);
            d = (sv * r) >>> 14;
            q = (d * d) >>> 14;
            a1 = a1 + d;
            if (a1 > 67108863) a1 = 67108863;
            if (a1 < -67108864) a1 = -67108864;
            a2 = a2 + q;
            if (a2 > 134217727) a2 = 134217727;
            a = step(a);
            b = step(b);
        end
    endfunction

    task automatic kick(input logic [17:0] m, input logic [17:0] sv, input logic [17:0] sg);
        @(negedge CLK);
        mu = m;
        s = sv;
        sigma = sg;
        start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        c0 = ecnt;
    endtask

    initial begin
        #1;
        chk("reset_acc1", acc1, 0);
        chk("reset_acc2", acc2, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        // deterministic batch: dS=276, q=4 each sample
        kick(18'd184, 18'd24576, 18'd0);
        repeat (4) @(posedge CLK);
        #1 chk("lat_edge4_acc1", acc1, 0);
        @(posedge CLK);
        #1 chk("first_acc1", acc1, 276);
        chk("first_acc2", acc2, 4);
        repeat (N - 2) @(posedge CLK);
        #1 chk("edge_n3_acc1", acc1, 70380);
        chk("edge_n3_acc2", acc2, 1020);
        @(posedge CLK);
        #1 chk("det_acc1", acc1, 70656);
        chk("det_acc2", acc2, 1024);
        repeat (5) @(posedge CLK);
        #1 chk("hold_acc1", acc1, 70656);

        // second pulse mid-run and a pulse on the IDLE-return edge are both ignored
        kick(18'd184, 18'd24576, 18'd0);
        repeat (20) @(posedge CLK);
        @(negedge CLK);
        mu = 18'd0;
        s = 18'd0;
        start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        repeat (N + 4 - 22) @(posedge CLK);
        @(negedge CLK) start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        chk("restart_acc1", acc1, 70656);
        chk("restart_acc2", acc2, 1024);
        repeat (10) @(posedge CLK);
        #1 chk("idle_edge_start_acc1", acc1, 70656);

        // zero drift and volatility: outputs cleared and stay zero
        kick(18'd0, 18'd100000, 18'd0);
        repeat (100) @(posedge CLK);
        #1 chk("zero_mid_acc1", acc1, 0);
        chk("zero_mid_acc2", acc2, 0);
        repeat (N + 4 - 100) @(posedge CLK);
        #1 chk("zero_end_acc1", acc1, 0);
        chk("zero_end_acc2", acc2, 0);

        // saturation: dS=2097128, acc1 saturates on sample 33
        kick(18'd131071, 18'd262143, 18'd0);
        repeat (36) @(posedge CLK);
        #1 chk("sat_pre_acc1", acc1, 67108096);
        chk("sat_pre_acc2", acc2, 134217727);
        repeat (N + 4 - 36) @(posedge CLK);
        #1 chk("sat_acc1", acc1, 67108863);
        chk("sat_acc2", acc2, 134217727);
        repeat (5) @(posedge CLK);
        #1 chk("sat_hold_acc1", acc1, 67108863);

        // asynchronous reset mid-batch
        kick(18'd184, 18'd24576, 18'd0);
        repeat (50) @(posedge CLK);
        #2 RST = 1'b1;
        #1 chk("async_rst_acc1", acc1, 0);
        chk("async_rst_acc2", acc2, 0);

        // nominal random batch, repeated from an identical reset point
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        kick(18'd184, 18'd24576, 18'd3408);
        repeat (N + 4) @(posedge CLK);
        #1 model(c0, 184, 24576, 3408, e1, e2);
        r1a = acc1;
        r1b = acc2;
        chk("nom_acc1_model", acc1, e1);
        chk("nom_acc2_model", acc2, e2);
        chk("nom_acc1_range", longint'(acc1 >= -496044 && acc1 <= 637356), 1);
        chk("nom_acc2_pos", longint'(acc2 > 0), 1);
        @(negedge CLK) RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        kick(18'd184, 18'd24576, 18'd3408);
        repeat (N + 4) @(posedge CLK);
        #1 chk("rep_acc1", acc1, r1a);
        chk("rep_acc2", acc2, r1b);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
